// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2,
    HOLD  = 2'd3
  } if_state_e;

  localparam logic [31:0] IF_NOP  = 32'h0000_0000;
  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/if_prefetch_fifo.sv
// Two-entry prefetch FIFO (instruction word + its PC+4) used only when
// IF_PREFETCH_EN is defined. Flush has priority over push/pop.
module if_prefetch_fifo #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic [WIDTH-1:0] push_pc,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic [WIDTH-1:0] head_pc,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] data_q [2];
  logic [WIDTH-1:0] data_d [2];
  logic [WIDTH-1:0] pc_q   [2];
  logic [WIDTH-1:0] pc_d   [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  assign full      = (count_q == 2'd2);
  assign empty     = (count_q == 2'd0);
  assign head_data = data_q[rd_ptr_q];
  assign head_pc   = pc_q[rd_ptr_q];
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;

  // Next pointer/count/storage values.
  always_comb begin
    data_d   = data_q;
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        data_d[wr_ptr_q] = push_data;
        pc_d[wr_ptr_q]   = push_pc;
        wr_ptr_d         = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q   <= '{default: '0};
      pc_q     <= '{default: '0};
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      data_q   <= data_d;
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Optional build macro IF_PREFETCH_EN: replaces the single hold register and
// HOLD state with a 2-entry prefetch FIFO that keeps fetching under freeze.
module if_stage
  import if_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  branch_taken,
  input  logic [WORD_WIDTH-1:0] branch_addr,
  output logic                  imem_req,
  output logic [WORD_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [WORD_WIDTH-1:0] imem_rdata,
  output logic [WORD_WIDTH-1:0] pc_out,
  output logic [WORD_WIDTH-1:0] instruction_out,
  output logic                  valid_out
);

  localparam logic [WORD_WIDTH-1:0] STEP = WORD_WIDTH'(PC_STEP);
  localparam logic [WORD_WIDTH-1:0] NOP  = WORD_WIDTH'(IF_NOP);

  if_state_e             state_q, state_d;
  logic [WORD_WIDTH-1:0] pc_q, pc_d;
  logic [WORD_WIDTH-1:0] addr_q, addr_d;
  logic                  req_q, req_d;
  logic [WORD_WIDTH-1:0] ifid_pc_q, ifid_pc_d;
  logic [WORD_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
  logic                  ifid_valid_q, ifid_valid_d;
  logic [WORD_WIDTH-1:0] pc_next;
  logic                  xfer;

  assign xfer            = req_q && imem_ack;
  assign pc_next         = pc_q + STEP;
  assign imem_req        = req_q;
  assign imem_addr       = addr_q;
  assign pc_out          = ifid_pc_q;
  assign instruction_out = ifid_instr_q;
  assign valid_out       = ifid_valid_q;

`ifdef IF_PREFETCH_EN
  logic                  fifo_push, fifo_pop, fifo_flush;
  logic                  fifo_full, fifo_empty, fifo_full_next;
  logic [WORD_WIDTH-1:0] fifo_head_data, fifo_head_pc;

  if_prefetch_fifo #(.WIDTH(WORD_WIDTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (imem_rdata),
    .push_pc   (pc_next),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .head_data (fifo_head_data),
    .head_pc   (fifo_head_pc),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );
`else
  logic [WORD_WIDTH-1:0] hold_pc_q, hold_pc_d;
  logic [WORD_WIDTH-1:0] hold_instr_q, hold_instr_d;
`endif

  // Next-state, PC, IF/ID and registered memory-port outputs.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
`ifdef IF_PREFETCH_EN
    fifo_push    = 1'b0;
    fifo_pop     = 1'b0;
    fifo_flush   = branch_taken;
`else
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
`endif

    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (branch_taken) begin
          pc_d         = branch_addr;
          ifid_instr_d = NOP;
          ifid_valid_d = 1'b0;
        end
      end
      FETCH: begin
        if (branch_taken) begin
          pc_d         = branch_addr;
          ifid_instr_d = NOP;
          ifid_valid_d = 1'b0;
          // An outstanding request must finish at its old address first.
          state_d      = (req_q && !xfer) ? DROP : FETCH;
        end else begin
`ifdef IF_PREFETCH_EN
          if (xfer) pc_d = pc_next;
          if (!freeze) begin
            // FIFO head is older than the word arriving now; bypass only when empty.
            if (!fifo_empty) begin
              ifid_pc_d    = fifo_head_pc;
              ifid_instr_d = fifo_head_data;
              ifid_valid_d = 1'b1;
              fifo_pop     = 1'b1;
              fifo_push    = xfer;
            end else if (xfer) begin
              ifid_pc_d    = pc_next;
              ifid_instr_d = imem_rdata;
              ifid_valid_d = 1'b1;
            end else begin
              ifid_instr_d = NOP;
              ifid_valid_d = 1'b0;
            end
          end else begin
            fifo_push = xfer;
          end
`else
          if (freeze) begin
            if (xfer) begin
              hold_pc_d    = pc_next;
              hold_instr_d = imem_rdata;
              pc_d         = pc_next;
              state_d      = HOLD;
            end
          end else if (xfer) begin
            ifid_pc_d    = pc_next;
            ifid_instr_d = imem_rdata;
            ifid_valid_d = 1'b1;
            pc_d         = pc_next;
          end else begin
            ifid_instr_d = NOP;
            ifid_valid_d = 1'b0;
          end
`endif
        end
      end
      DROP: begin
        if (branch_taken) begin
          pc_d         = branch_addr;
          ifid_instr_d = NOP;
          ifid_valid_d = 1'b0;
        end else if (!freeze) begin
          ifid_instr_d = NOP;
          ifid_valid_d = 1'b0;
        end
        if (xfer) state_d = FETCH;
      end
      HOLD: begin
`ifdef IF_PREFETCH_EN
        state_d = FETCH;
`else
        if (branch_taken) begin
          pc_d         = branch_addr;
          ifid_instr_d = NOP;
          ifid_valid_d = 1'b0;
          hold_pc_d    = '0;
          hold_instr_d = NOP;
          state_d      = FETCH;
        end else if (!freeze) begin
          ifid_pc_d    = hold_pc_q;
          ifid_instr_d = hold_instr_q;
          ifid_valid_d = 1'b1;
          state_d      = FETCH;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

`ifdef IF_PREFETCH_EN
    fifo_full_next = !fifo_flush &&
                     (fifo_full ? !(fifo_pop && !fifo_push)
                                : (!fifo_empty && fifo_push && !fifo_pop));
    req_d = (state_d == DROP) || ((state_d == FETCH) && !fifo_full_next);
`else
    req_d = (state_d == FETCH) || (state_d == DROP);
`endif
    // DROP keeps presenting the pre-branch address until its transfer.
    addr_d = (state_d == DROP) ? addr_q : pc_d;
  end

  // FSM and pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      addr_q       <= '0;
      req_q        <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP;
      ifid_valid_q <= 1'b0;
`ifndef IF_PREFETCH_EN
      hold_pc_q    <= '0;
      hold_instr_q <= NOP;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      req_q        <= req_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
`ifndef IF_PREFETCH_EN
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
`endif
    end
  end

endmodule
